// File: rtl/wb_sram_burst_slave.sv
// Wishbone B3 SRAM slave: classic cycles plus registered-feedback incrementing/wrapping bursts,
// byte-lane writes, ERR on out-of-range beats. One wait state on the first beat, then one beat per clock.
module wb_sram_burst_slave #(
   parameter int unsigned                 WB_ADDR_WIDTH = 32,
   parameter int unsigned                 WB_DATA_WIDTH = 32,
   parameter int unsigned                 MEM_DEPTH     = 1024,
   parameter logic [WB_ADDR_WIDTH-1:0]    BASE_ADDR     = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WB_ADDR_WIDTH-1:0]       ADR,
   input  logic [WB_DATA_WIDTH-1:0]       DAT_W,
   input  logic [WB_DATA_WIDTH/8-1:0]     SEL,
   input  logic                           CYC,
   input  logic                           STB,
   input  logic                           WE,
   input  logic [2:0]                     CTI,
   input  logic [1:0]                     BTE,
   output logic [WB_DATA_WIDTH-1:0]       DAT_R,
   output logic                           ACK,
   output logic                           ERR
);

   localparam int unsigned NB = WB_DATA_WIDTH / 8;
   localparam int unsigned LB = (NB > 1) ? $clog2(NB) : 0;
   localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned NW = IW + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                    state;
   logic [WB_DATA_WIDTH-1:0]  mem [MEM_DEPTH];
   logic [IW-1:0]             beat_idx;
   logic [WB_ADDR_WIDTH-1:0]  idx;
   logic [WB_ADDR_WIDTH-1:0]  beat_adr;
   logic                      in_range;
   logic                      beat_live;
   logic [NW-1:0]             wrap_mask;
   logic [NW-1:0]             nxt;
   logic                      nxt_ok;

   always_comb begin
      idx       = (ADR - BASE_ADDR) >> LB;
      in_range  = (ADR >= BASE_ADDR) && (idx < WB_ADDR_WIDTH'(MEM_DEPTH));
      beat_adr  = BASE_ADDR + (WB_ADDR_WIDTH'(beat_idx) << LB);
      // A beat only counts while the master still presents the address being ACKed.
      beat_live = ACK && CYC && STB && (ADR == beat_adr);
      case (BTE)
         2'b01:   wrap_mask = NW'(3);
         2'b10:   wrap_mask = NW'(7);
         2'b11:   wrap_mask = NW'(15);
         default: wrap_mask = '1;
      endcase
      // Extra top bit lets a linear increment past the last word be seen as out of range.
      nxt    = ({1'b0, beat_idx} & ~wrap_mask) | (({1'b0, beat_idx} + NW'(1)) & wrap_mask);
      nxt_ok = nxt < NW'(MEM_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (beat_live && WE) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (SEL[i]) mem[beat_idx][8*i +: 8] <= DAT_W[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ACK      <= 1'b0;
         ERR      <= 1'b0;
         DAT_R    <= '0;
         beat_idx <= '0;
      end else if (!CYC) begin
         state <= IDLE;
         ACK   <= 1'b0;
         ERR   <= 1'b0;
      end else if (ACK) begin
         if (beat_live && CTI == 3'b010) begin
            if (nxt_ok) begin
               state    <= BURST;
               beat_idx <= nxt[IW-1:0];
               DAT_R    <= mem[nxt[IW-1:0]];
            end else begin
               state <= IDLE;
               ACK   <= 1'b0;
               ERR   <= 1'b1;
            end
         end else begin
            state <= IDLE;
            ACK   <= 1'b0;
         end
      end else if (ERR) begin
         state <= IDLE;
         ERR   <= 1'b0;
      end else if (state == IDLE && STB) begin
         if (in_range) begin
            ACK      <= 1'b1;
            beat_idx <= idx[IW-1:0];
            DAT_R    <= mem[idx[IW-1:0]];
         end else begin
            ERR <= 1'b1;
         end
      end else begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Scoreboard bench for wb_sram_burst_slave: the driver queues expected responses,
// a negedge monitor pops and checks every ACK/ERR the slave presents.
module tb_wb_sram_burst_slave;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ADR = '0;
   logic [31:0] DAT_W = '0;
   logic [3:0]  SEL = '0;
   logic        CYC = 1'b0;
   logic        STB = 1'b0;
   logic        WE = 1'b0;
   logic [2:0]  CTI = '0;
   logic [1:0]  BTE = '0;
   logic [31:0] DAT_R;
   logic        ACK;
   logic        ERR;

   wb_sram_burst_slave #(
      .WB_ADDR_WIDTH (32),
      .WB_DATA_WIDTH (32),
      .MEM_DEPTH     (DEPTH),
      .BASE_ADDR     (BASE)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .ADR   (ADR),
      .DAT_W (DAT_W),
      .SEL   (SEL),
      .CYC   (CYC),
      .STB   (STB),
      .WE    (WE),
      .CTI   (CTI),
      .BTE   (BTE),
      .DAT_R (DAT_R),
      .ACK   (ACK),
      .ERR   (ERR)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          rel;
      bit          err;
      bit          chk;
      logic [31:0] d;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          xfer_base = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] b_adr [16];
   logic [31:0] b_wd  [16];
   int unsigned w4 [4] = '{6, 7, 4, 5};
   int unsigned w8 [8] = '{13, 14, 15, 8, 9, 10, 11, 12};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] A(input int unsigned i);
      return BASE + 32'(i * 4);
   endfunction

   task automatic exp_rsp(input int rel, input bit err, input bit chk, input logic [31:0] d,
                          input string tag);
      exp_t e;
      e.rel = rel; e.err = err; e.chk = chk; e.d = d; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (ACK || ERR)) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_rsp: cyc=%0d ACK=%b ERR=%b DAT_R=%h, required no response",
                     cyc, ACK, ERR, DAT_R);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ((ACK && ERR) || (ERR != e.err) || (ACK != !e.err) || ((cyc - xfer_base) != e.rel) ||
                (e.chk && DAT_R !== e.d)) begin
               miscompares++;
               $display("FAIL rsp_%s: rel=%0d ACK=%b ERR=%b DAT_R=%h, required rel=%0d ACK=%b ERR=%b DAT_R=%h",
                        e.tag, cyc - xfer_base, ACK, ERR, DAT_R, e.rel, !e.err, e.err,
                        e.chk ? e.d : DAT_R);
            end
         end
      end
   end

   task automatic drive_beat(input int unsigned k, input int unsigned n, input logic [2:0] last_cti);
      CYC   = 1'b1;
      STB   = 1'b1;
      ADR   = b_adr[k];
      DAT_W = b_wd[k];
      CTI   = (k == n - 1) ? last_cti : 3'b010;
   endtask

   task automatic bus_idle();
      CYC = 1'b0; STB = 1'b0; WE = 1'b0; CTI = 3'b000; BTE = 2'b00;
   endtask

   // Called #1 after a posedge; beat k is held through the cycle its ACK is expected in.
   task automatic xfer(input int unsigned n, input logic we, input logic [3:0] sel,
                       input logic [1:0] bte, input logic [2:0] last_cti);
      xfer_base = cyc;
      WE = we; SEL = sel; BTE = bte;
      drive_beat(0, n, last_cti);
      @(posedge clk);
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (k + 1 < n) drive_beat(k + 1, n, last_cti);
         else bus_idle();
      end
   endtask

   task automatic classic_wr(input int unsigned i, input logic [31:0] d, input logic [3:0] sel);
      b_adr[0] = A(i); b_wd[0] = d;
      exp_rsp(1, 1'b0, 1'b0, '0, "classic_wr");
      xfer(1, 1'b1, sel, 2'b00, 3'b000);
   endtask

   task automatic classic_rd(input int unsigned i, input logic [31:0] d);
      b_adr[0] = A(i); b_wd[0] = '0;
      exp_rsp(1, 1'b0, 1'b1, d, "classic_rd");
      xfer(1, 1'b0, 4'hF, 2'b00, 3'b000);
   endtask

   task automatic classic_err(input logic [31:0] adr, input logic we);
      b_adr[0] = adr; b_wd[0] = 32'hDEAD_BEEF;
      exp_rsp(1, 1'b1, 1'b0, '0, "classic_err");
      xfer(1, we, 4'hF, 2'b00, 3'b000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ack", {31'b0, ACK}, 32'h0);
      check("reset_err", {31'b0, ERR}, 32'h0);
      check("reset_dat_r", DAT_R, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      classic_wr(2, 32'hA5A5_1234, 4'b1111);
      classic_rd(2, 32'hA5A5_1234);

      classic_wr(3, 32'h1111_1111, 4'b1111);
      classic_wr(3, 32'hFFFF_FFFF, 4'b0101);
      classic_rd(3, 32'h11FF_11FF);

      for (int unsigned k = 0; k < 12; k++) begin
         b_adr[k] = A(4 + k); b_wd[k] = 32'(4 + k);
         exp_rsp(int'(k) + 1, 1'b0, 1'b0, '0, "init_wr");
      end
      xfer(12, 1'b1, 4'hF, 2'b00, 3'b111);

      for (int unsigned k = 0; k < 4; k++) begin
         b_adr[k] = A(4 + k); b_wd[k] = '0;
         exp_rsp(int'(k) + 1, 1'b0, 1'b1, 32'(4 + k), "lin_rd");
      end
      xfer(4, 1'b0, 4'hF, 2'b00, 3'b111);

      for (int unsigned k = 0; k < 4; k++) begin
         b_adr[k] = A(w4[k]); b_wd[k] = '0;
         exp_rsp(int'(k) + 1, 1'b0, 1'b1, 32'(w4[k]), "wrap4_rd");
      end
      xfer(4, 1'b0, 4'hF, 2'b01, 3'b111);

      for (int unsigned k = 0; k < 8; k++) begin
         b_adr[k] = A(w8[k]); b_wd[k] = 32'h800 + 32'(w8[k]);
         exp_rsp(int'(k) + 1, 1'b0, 1'b1, 32'(w8[k]), "wrap8_wr");
      end
      xfer(8, 1'b1, 4'hF, 2'b10, 3'b111);

      for (int unsigned k = 0; k < 8; k++) begin
         b_adr[k] = A(8 + k); b_wd[k] = '0;
         exp_rsp(int'(k) + 1, 1'b0, 1'b1, 32'h800 + 32'(8 + k), "wrap8_chk");
      end
      xfer(8, 1'b0, 4'hF, 2'b00, 3'b111);

      classic_wr(0, 32'h0BAD_F00D, 4'hF);
      classic_err(A(DEPTH), 1'b0);
      classic_err(BASE - 32'd4, 1'b1);

      b_adr[0] = A(62); b_wd[0] = 32'h6200_003E;
      b_adr[1] = A(63); b_wd[1] = 32'h6200_003F;
      b_adr[2] = A(64); b_wd[2] = 32'h6200_0040;
      exp_rsp(1, 1'b0, 1'b0, '0, "range_b0");
      exp_rsp(2, 1'b0, 1'b0, '0, "range_b1");
      exp_rsp(3, 1'b1, 1'b0, '0, "range_err");
      xfer(3, 1'b1, 4'hF, 2'b00, 3'b111);

      b_adr[0] = A(62); b_adr[1] = A(63);
      exp_rsp(1, 1'b0, 1'b1, 32'h6200_003E, "range_rd0");
      exp_rsp(2, 1'b0, 1'b1, 32'h6200_003F, "range_rd1");
      xfer(2, 1'b0, 4'hF, 2'b00, 3'b111);
      classic_rd(0, 32'h0BAD_F00D);

      // Abort: STB dropped during the second beat's ACK cycle.
      classic_wr(21, 32'hDEAD_0021, 4'hF);
      xfer_base = cyc;
      exp_rsp(1, 1'b0, 1'b0, '0, "abort_b0");
      exp_rsp(2, 1'b0, 1'b1, 32'hDEAD_0021, "abort_b1");
      WE = 1'b1; SEL = 4'hF; BTE = 2'b00;
      CYC = 1'b1; STB = 1'b1; ADR = A(20); DAT_W = 32'h2020_2020; CTI = 3'b010;
      @(posedge clk);
      @(posedge clk); #1;
      ADR = A(21); DAT_W = 32'hFFFF_FFFF; STB = 1'b0;
      @(posedge clk); #1;
      bus_idle();
      classic_rd(20, 32'h2020_2020);
      classic_rd(21, 32'hDEAD_0021);

      // Reset asserted while the second beat is being ACKed.
      xfer_base = cyc;
      exp_rsp(1, 1'b0, 1'b1, 32'h4, "rstburst_b0");
      WE = 1'b0; SEL = 4'hF; BTE = 2'b00;
      CYC = 1'b1; STB = 1'b1; ADR = A(4); CTI = 3'b010;
      @(posedge clk);
      @(posedge clk); #1;
      ADR = A(5);
      #2 rst = 1'b1;
      #1;
      check("midrst_ack", {31'b0, ACK}, 32'h0);
      check("midrst_err", {31'b0, ERR}, 32'h0);
      check("midrst_dat_r", DAT_R, 32'h0);
      bus_idle();
      rst = 1'b0;
      @(posedge clk); #1;
      classic_wr(5, 32'h5A5A_5A5A, 4'hF);
      classic_rd(5, 32'h5A5A_5A5A);

      repeat (4) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
